// File: rtl/lpm_compare_sar_pkg.sv
// Shared definitions for the lpm_compare successive-approximation controller:
// FSM state encoding, representation strings and index-width helper.
package lpm_compare_sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRIAL = 2'd1,
        ST_DONE  = 2'd2
    } sar_state_e;

    localparam string REP_UNSIGNED = "UNSIGNED";
    localparam string REP_SIGNED   = "SIGNED";

    // Width of a bit pointer addressing a w-bit code; never zero.
    function automatic int unsigned idx_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/lpm_sar_wait_cnt.sv
// Comparator-latency wait counter: counts clken-qualified edges up to
// lpm_pipeline and raises tc while it sits at the terminal count.
module lpm_sar_wait_cnt
    import lpm_compare_sar_pkg::*;
#(
    parameter int unsigned lpm_pipeline = 1
) (
    input  logic clock,
    input  logic aclr_n,
    input  logic clken,
    input  logic clr,
    output logic tc
);

    localparam int unsigned     CW   = $clog2(lpm_pipeline + 1);
    localparam logic [CW-1:0]   TERM = CW'(lpm_pipeline);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!tc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            cnt_q <= '0;
        end else if (clken) begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TERM);

endmodule

// File: rtl/lpm_compare_sar.sv
// Successive-approximation search driving the datab side of an lpm_compare.
// Optional LPM_COMPARE_SAR_EARLY_EXIT_EN stops the search on the first aeb hit.
module lpm_compare_sar
    import lpm_compare_sar_pkg::*;
#(
    parameter int unsigned lpm_width          = 1,
    parameter string       lpm_representation = "UNSIGNED",
    parameter int unsigned lpm_pipeline       = 0
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic                 clken,
    input  logic                 start,
    input  logic                 ageb,
    input  logic                 aeb,
    output logic [lpm_width-1:0] datab,
    output logic [lpm_width-1:0] result,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned    W         = lpm_width;
    localparam int unsigned    BW        = idx_w(W);
    localparam bit             IS_SIGNED = (lpm_representation == REP_SIGNED);
    localparam logic [W-1:0]   MSB       = W'(1) << (W - 1);
    localparam logic [W-1:0]   FLIP      = IS_SIGNED ? MSB : '0;
    localparam logic [BW-1:0]  TOP_IDX   = BW'(W - 1);

    // The trial code is offset-binary; signed comparators see its MSB inverted.
    function automatic logic [W-1:0] map_code(input logic [W-1:0] t);
        return t ^ FLIP;
    endfunction

    sar_state_e    state_q, state_d;
    logic [W-1:0]  t_q, t_d;
    logic [W-1:0]  result_q, result_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tc;
    logic          cnt_clr;
    logic          hit;

`ifdef LPM_COMPARE_SAR_EARLY_EXIT_EN
    assign hit = aeb;
`else
    assign hit = 1'b0;
    logic unused_aeb;
    assign unused_aeb = aeb;
`endif

    // Counter restarts on every new trial so each bit waits a full comparator latency.
    assign cnt_clr = (state_q != ST_TRIAL) || tc;

    if (lpm_pipeline > 0) begin : g_wait
        lpm_sar_wait_cnt #(
            .lpm_pipeline(lpm_pipeline)
        ) u_wait (
            .clock  (clock),
            .aclr_n (aclr_n),
            .clken  (clken),
            .clr    (cnt_clr),
            .tc     (tc)
        );
    end else begin : g_nowait
        assign tc = 1'b1;
        logic unused_clr;
        assign unused_clr = cnt_clr;
    end

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        bit_d    = bit_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    t_d     = MSB;
                    bit_d   = TOP_IDX;
                    busy_d  = 1'b1;
                    state_d = ST_TRIAL;
                end
            end
            ST_TRIAL: begin
                if (tc) begin
                    if (hit) begin
                        result_d = map_code(t_q);
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        t_d[bit_q] = ageb;
                        if (bit_q != '0) begin
                            t_d[bit_q - BW'(1)] = 1'b1;
                            bit_d               = bit_q - BW'(1);
                        end else begin
                            result_d = map_code(t_d);
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            state_d  = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset code maps to datab==0 in either representation.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= ST_IDLE;
            t_q      <= FLIP;
            bit_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (clken) begin
            state_q  <= state_d;
            t_q      <= t_d;
            bit_q    <= bit_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign datab  = map_code(t_q);
    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
